// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// Op codes, FSM states and the default operand width.
package muldiv_pkg;
   localparam int WIDTH_DEF = 32;

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_CALC = 2'b01,
      S_DONE = 2'b10
   } state_e;
endpackage

// File: rtl/muldiv_abs.sv
// Operand magnitude/sign split.
// With sgn=0 the value passes through as unsigned.
module muldiv_abs
   import muldiv_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic [WIDTH-1:0] val,
   input  logic             sgn,
   output logic [WIDTH-1:0] mag,
   output logic             neg
);
   assign neg = sgn & val[WIDTH-1];
   assign mag = neg ? -val : val;
endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO.
// Shift-add multiply and restoring divide, one bit per cycle.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] opA,
   input  logic [WIDTH-1:0] opB,
   input  logic             mthi,
   input  logic             mtlo,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   localparam int CW = $clog2(WIDTH);

   state_e             state, state_n;
   logic [CW-1:0]      cnt;
   logic               is_div, neg_q, neg_r, dz;
   logic [WIDTH-1:0]   ma, mb;
   logic [2*WIDTH-1:0] acc, acc_n, prod;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic               a_neg, b_neg;
   logic               sgn_in, accept, last;
   logic [WIDTH:0]     sum, trial, diff;
   logic [WIDTH-1:0]   quo, rem, res_hi, res_lo;

   assign sgn_in = ~op[0];

   muldiv_abs #(.WIDTH(WIDTH)) u_abs_a (
      .val (opA),
      .sgn (sgn_in),
      .mag (a_mag),
      .neg (a_neg)
   );

   muldiv_abs #(.WIDTH(WIDTH)) u_abs_b (
      .val (opB),
      .sgn (sgn_in),
      .mag (b_mag),
      .neg (b_neg)
   );

   assign busy        = (state == S_CALC);
   assign done        = (state == S_DONE);
   assign div_by_zero = done & dz;
   assign accept      = start & (state != S_CALC);
   assign last        = (state == S_CALC) && (cnt == '0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n = state;
      unique case (state)
         S_IDLE:  if (start) state_n = S_CALC;
         S_CALC:  if (cnt == '0) state_n = S_DONE;
         S_DONE:  state_n = start ? S_CALC : S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   // acc is {partial, multiplier} for multiply and {remainder, quotient} for divide
   always_comb begin
      sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? ma : '0)};
      trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      diff  = trial - {1'b0, mb};
      if (is_div) begin
         if (diff[WIDTH])
            acc_n = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
         else
            acc_n = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end else begin
         acc_n = {sum, acc[WIDTH-1:1]};
      end
   end

   always_comb begin
      prod = neg_q ? -acc_n : acc_n;
      quo  = acc_n[WIDTH-1:0];
      rem  = acc_n[2*WIDTH-1:WIDTH];
      if (dz) begin
         res_hi = neg_r ? -ma : ma;
         res_lo = '1;
      end else if (is_div) begin
         res_hi = neg_r ? -rem : rem;
         res_lo = neg_q ? -quo : quo;
      end else begin
         res_hi = prod[2*WIDTH-1:WIDTH];
         res_lo = prod[WIDTH-1:0];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt    <= '0;
         is_div <= 1'b0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         dz     <= 1'b0;
         ma     <= '0;
         mb     <= '0;
         acc    <= '0;
      end else if (accept) begin
         cnt    <= CW'(WIDTH-1);
         is_div <= op[1];
         neg_q  <= a_neg ^ b_neg;
         neg_r  <= a_neg;
         dz     <= op[1] & ~(|opB);
         ma     <= a_mag;
         mb     <= b_mag;
         acc    <= {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
      end else if (state == S_CALC) begin
         cnt    <= cnt - CW'(1);
         acc    <= acc_n;
      end
   end

   // mthi/mtlo land even alongside start; the result overwrites them later
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hi <= '0;
         lo <= '0;
      end else if (last) begin
         hi <= res_hi;
         lo <= res_lo;
      end else if (state != S_CALC) begin
         if (mthi) hi <= wdata;
         if (mtlo) lo <= wdata;
      end
   end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative multi-cycle multiply/divide unit that owns the HI/LO register pair for MULT, MULTU, DIV and DIVU. It sits beside and downstream of the single-cycle ALU. The control unit issues an operation with a start pulse and stalls the pipeline while busy is high. The ALU/writeback path reads hi and lo for MFHI and MFLO, and writes them through mthi/mtlo.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits; compute phase lasts WIDTH cycles.

Ports:
clk  input  1  system clock, all state changes on rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  begin operation; sampled only when busy=0
op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
opA  input  WIDTH  multiplicand / dividend (rs)
opB  input  WIDTH  multiplier / divisor (rt)
mthi  input  1  write wdata to HI
mtlo  input  1  write wdata to LO
wdata  input  WIDTH  data for mthi/mtlo
busy  output  1  high while computing
done  output  1  one-cycle pulse when HI/LO hold a new result
div_by_zero  output  1  valid with done; 1 if DIV/DIVU had opB=0
hi  output  WIDTH  HI register (MFHI source)
lo  output  WIDTH  LO register (MFLO source)

Behaviour:
- Reset (async, immediate, also mid-operation): state=IDLE, counter=0, busy=0, done=0, div_by_zero=0, hi=0, lo=0. The in-flight operation is discarded.
- FSM states: IDLE, CALC, DONE.
  - IDLE/DONE with start=1: latch op, operand magnitudes, result signs, counter=WIDTH-1; go to CALC.
  - DONE with start=0: return to IDLE.
  - CALC: one iteration per edge. At counter=0, write the final hi/lo, then go to DONE.
- Latency: start sampled on edge E0. busy=1 from E0 to E32 (WIDTH=32). hi/lo update at E32. done=1 for exactly one cycle after E32. Back-to-back start in the DONE cycle is accepted.
- start while busy=1 is ignored. mthi/mtlo while busy=1 are ignored.
- mthi/mtlo when busy=0: the register is written at that edge. If start arrives on the same edge, the write still happens and is later overwritten by the result.
- Multiply: shift-add, one multiplier bit per cycle. {hi,lo} holds the 2*WIDTH product.
  - MULTU: unsigned product.
  - MULT: product of magnitudes, two's-complement negated if the operand signs differ.
- Divide: restoring division, one quotient bit per cycle. lo=quotient, hi=remainder.
  - DIVU: unsigned.
  - DIV: magnitudes divided. Quotient is negated if signs differ; remainder takes the dividend's sign (truncating division).
  - Signed overflow 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- Divide by zero: full latency still applies. lo=all ones, hi=opA as issued. div_by_zero=1 during the done cycle, else 0.
- Multiply never sets div_by_zero.
- hi/lo hold their values between operations. They are not modified during CALC; intermediate state is kept in internal registers.

Decomposition:
- Package muldiv_pkg holds:
  - op encodings OP_MULT, OP_MULTU, OP_DIV, OP_DIVU
  - FSM state encoding S_IDLE, S_CALC, S_DONE
  - default WIDTH constant
- One sub-module is natural: muldiv_abs (combinational). It produces the magnitude and sign of an operand under a signed/unsigned select, and is instanced twice. The FSM, counter and datapath stay in muldiv_unit.

Test Plan:
1. MULTU opA=0xFFFFFFFF opB=0xFFFFFFFF -> busy for 32 cycles, then done pulse; hi=0xFFFFFFFE, lo=0x00000001, div_by_zero=0.
2. MULT opA=0xFFFFFFFD (-3), opB=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21). Next, DIV opA=0xFFFFFFF9 (-7), opB=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
3. DIVU opA=100, opB=0 -> lo=0xFFFFFFFF, hi=100, div_by_zero=1 for one cycle. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
4. Handshake: start MULTU 5*6, pulse start again with other operands at cycle 10 -> ignored; lo=30 at done. Start issued in the done cycle -> accepted, busy next edge.
5. mthi wdata=0x1234 in IDLE -> hi=0x1234 after the edge. mtlo while busy -> lo unchanged at that edge; lo=result at done.
6. Assert reset at cycle 10 of a MULT, between clock edges -> busy, done, hi, lo go to 0 immediately with no clock edge. After release, no done pulse appears.
